// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit signal bundle: pipeline hazard inputs toward the controller and
// stall/flush controls plus debug counters back to the pipeline.
interface pipeline_hazard_ctrl_if;
    logic        memread_ex;
    logic [4:0]  dst_ex;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        branch_taken_ex;
    logic        md_req_id;
    logic        md_done;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_start;
    logic        md_timeout;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output memread_ex, dst_ex, rs_id, rt_id, branch_taken_ex, md_req_id, md_done,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout,
        input  state, stall_cnt, flush_cnt
    );

    modport slave (
        input  memread_ex, dst_ex, rs_id, rt_id, branch_taken_ex, md_req_id, md_done,
        output pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_timeout,
        output state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and optional
// mul/div stall sequencing with timeout (enabled by the MULDIV_EN macro).
module pipeline_hazard_ctrl #(
    parameter int MD_MAX_CYCLES = 64
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        FLUSH   = 2'b01,
        MD_WAIT = 2'b10,
        LU_HOLD = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_start;
    logic        load_use;
    logic        md_req, md_done, md_expire;

    assign load_use = hz.memread_ex && (hz.dst_ex != 5'd0) &&
                      ((hz.dst_ex == hz.rs_id) || (hz.dst_ex == hz.rt_id));

`ifdef MULDIV_EN
    localparam int CW = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;

    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          md_timeout_q, md_timeout_d;

    assign md_req    = hz.md_req_id;
    assign md_done   = hz.md_done;
    assign md_expire = (md_cnt_q == CW'(MD_MAX_CYCLES - 1));

    // A done pulse on the expiry cycle wins over the timeout.
    always_comb begin
        md_cnt_d     = md_cnt_q;
        md_timeout_d = md_timeout_q;
        if (md_start) begin
            md_cnt_d = '0;
        end else if (state_q == MD_WAIT && !md_done) begin
            md_cnt_d = md_cnt_q + CW'(1);
            if (md_expire) begin
                md_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign hz.md_timeout = md_timeout_q;
`else
    logic unused_md;

    assign md_req        = 1'b0;
    assign md_done       = 1'b0;
    assign md_expire     = 1'b0;
    assign hz.md_timeout = 1'b0;
    assign unused_md     = ^{hz.md_req_id, hz.md_done, MD_MAX_CYCLES[0]};
`endif

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (hz.branch_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = FLUSH;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = LU_HOLD;
                    end else if (md_req) begin
                        md_start    = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = MD_WAIT;
                    end
                end
                FLUSH, LU_HOLD: state_d = RUN;
                MD_WAIT: begin
                    if (md_done) begin
                        state_d = RUN;
                    end else if (md_expire) begin
                        // Abandon the stuck op: drop the waiting instruction and refetch.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = RUN;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_write && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (ifid_flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.md_start    = md_start;
    assign hz.state       = state_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected controls, state and
// counters are queued at drive time and compared mid-cycle.
module tb_pipeline_hazard_ctrl;
    localparam int TB_MD_MAX = 12;

    localparam logic [1:0] S_RUN = 2'b00, S_FLUSH = 2'b01, S_MD = 2'b10, S_LU = 2'b11;
    // {pc_write, ifid_write, ifid_flush, idex_bubble, md_start}
    localparam logic [4:0] C_DEF = 5'b11000, C_LU = 5'b00010, C_BR = 5'b11110;
    localparam logic [4:0] C_MDS = 5'b00011, C_MDW = 5'b00010, C_TMO = 5'b11110;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic [15:0] flush;
        logic        tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(.MD_MAX_CYCLES(TB_MD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_stall  = 16'd0;
    logic [15:0] m_flush  = 16'd0;
    logic        m_tmo    = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cyc(input string tag, input bit r, input bit mr, input logic [4:0] dst,
                       input logic [4:0] rs, input logic [4:0] rt, input bit br, input bit mq,
                       input bit md, input logic [4:0] ectl, input logic [1:0] est);
        exp_t e, g;
        rst                = r;
        hz.memread_ex      = mr;
        hz.dst_ex          = dst;
        hz.rs_id           = rs;
        hz.rt_id           = rt;
        hz.branch_taken_ex = br;
        hz.md_req_id       = mq;
        hz.md_done         = md;
        e.tag   = tag;
        e.ctl   = ectl;
        e.st    = est;
        e.stall = m_stall;
        e.flush = m_flush;
        e.tmo   = m_tmo;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check_val({g.tag, "/ctl"}, 32'({hz.pc_write, hz.ifid_write, hz.ifid_flush,
                                        hz.idex_bubble, hz.md_start}), 32'(g.ctl));
        check_val({g.tag, "/state"}, 32'(hz.state), 32'(g.st));
        check_val({g.tag, "/stall_cnt"}, 32'(hz.stall_cnt), 32'(g.stall));
        check_val({g.tag, "/flush_cnt"}, 32'(hz.flush_cnt), 32'(g.flush));
        check_val({g.tag, "/md_timeout"}, 32'(hz.md_timeout), 32'(g.tmo));
        $display("%-12s rst=%0b ctl=%05b state=%0d stall=%0d flush=%0d tmo=%0b", g.tag, r,
                 {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.md_start},
                 hz.state, hz.stall_cnt, hz.flush_cnt, hz.md_timeout);
        if (r) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
            m_tmo   = 1'b0;
        end else begin
            if (!ectl[4]) m_stall++;
            if (ectl[2]) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [1:0] est);
        cyc(tag, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_DEF, est);
    endtask

    initial begin
        hz.memread_ex = 0; hz.dst_ex = 0; hz.rs_id = 0; hz.rt_id = 0;
        hz.branch_taken_ex = 0; hz.md_req_id = 0; hz.md_done = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset cycle with a pending request: outputs stay at defaults.
        cyc("rst", 1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, C_DEF, S_RUN);
        idle("idle0", S_RUN);

        // Load-use on rs, then hold, then back to run.
        cyc("lu_rs", 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, C_LU, S_RUN);
        cyc("lu_hold", 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, C_DEF, S_LU);
        idle("lu_run", S_RUN);
        // Load-use on rt.
        cyc("lu_rt", 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, C_LU, S_RUN);
        cyc("lu_rt_hold", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_DEF, S_LU);
        // r0 destination and non-matching or non-load cases never stall.
        cyc("lu_r0", 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, C_DEF, S_RUN);
        for (int i = 1; i < 4; i++) begin
            cyc($sformatf("nohaz%0d", i), 0, 1, 5'(i), 5'(i + 8), 5'(i + 16), 0, 0, 0, C_DEF, S_RUN);
        end
        cyc("noload", 0, 0, 5'd9, 5'd9, 5'd9, 0, 0, 0, C_DEF, S_RUN);

        // Branch beats load-use; FLUSH ignores a second branch.
        cyc("br_lu", 0, 1, 5'd3, 5'd3, 5'd3, 1, 0, 0, C_BR, S_RUN);
        cyc("flush", 0, 1, 5'd3, 5'd3, 5'd3, 1, 0, 0, C_DEF, S_FLUSH);
        idle("br_run", S_RUN);
        cyc("br_only", 0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, C_BR, S_RUN);
        idle("flush2", S_FLUSH);

`ifdef MULDIV_EN
        // Done arriving exactly at the expiry cycle counts as done.
        cyc("md_s0", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDS, S_RUN);
        for (int i = 1; i < TB_MD_MAX; i++) begin
            cyc($sformatf("md_w0_%0d", i), 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDW, S_MD);
        end
        cyc("md_edge", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_DEF, S_MD);
        idle("md_r0", S_RUN);

        // Genuine timeout: flush the waiting instruction, sticky flag.
        cyc("md_s1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDS, S_RUN);
        for (int i = 1; i < TB_MD_MAX; i++) begin
            cyc($sformatf("md_w1_%0d", i), 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDW, S_MD);
        end
        cyc("md_tmo", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_TMO, S_MD);
        m_tmo = 1'b1;
        idle("tmo_run", S_RUN);
        cyc("done_run", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_DEF, S_RUN);

        // Done ten cycles after the request; branches ignored while waiting.
        cyc("md_s2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDS, S_RUN);
        for (int i = 1; i < 10; i++) begin
            cyc($sformatf("md_w2_%0d", i), 0, 0, 5'd0, 5'd0, 5'd0, i[0], 1, 0, C_MDW, S_MD);
        end
        cyc("md_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_DEF, S_MD);
        idle("md_r2", S_RUN);

        // Reset on the second wait cycle clears everything.
        cyc("md_s3", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDS, S_RUN);
        cyc("md_w3_1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_MDW, S_MD);
        cyc("md_rst", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_DEF, S_MD);
        idle("post_rst", S_RUN);
`else
        // Without the mul/div option its inputs have no effect.
        cyc("md_off0", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_DEF, S_RUN);
        cyc("md_off1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, C_DEF, S_RUN);
        cyc("md_off2", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, C_DEF, S_RUN);
        cyc("md_lu", 0, 1, 5'd4, 5'd0, 5'd4, 0, 1, 0, C_LU, S_RUN);
        cyc("md_lu_h", 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, C_DEF, S_LU);
        cyc("mid_rst", 1, 1, 5'd4, 5'd4, 5'd0, 1, 1, 1, C_DEF, S_RUN);
        idle("post_rst", S_RUN);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
